// File: rtl/instr_encoder_loader_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_if
// Request handshake and instruction-memory write bus of instr_encoder_loader.
//   master : sequencer side, drives req_* and observes req_ready / imem_*
//   slave  : loader side, accepts req_* and drives req_ready / imem_*
// Signals:
//   req_valid/req_ready  request handshake
//   req_class            0 load,1 store,2 R,3 branch,4 I-ALU,5 jal,6 jalr,7 auipc
//   req_rd/rs1/rs2       register fields
//   req_funct3           funct3 field
//   req_funct7b5         instruction bit 30
//   req_imm              signed byte immediate (auipc: full upper value)
//   req_last             final instruction of the program
//   imem_we/addr/wdata   instruction-memory write port
// -----------------------------------------------------------------------------
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_class;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [2:0]        req_funct3;
    logic              req_funct7b5;
    logic [31:0]       req_imm;
    logic              req_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output req_valid, req_class, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7b5, req_imm, req_last,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_class, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7b5, req_imm, req_last,
        output req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Builds RV32I instruction words from field-level requests and writes them
// sequentially into instruction memory, with immediate range/alignment checks,
// address sequencing, end-of-program (done) and capacity (full) signalling.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse: clears address, count, done and full
//   bus        request handshake + imem write port (slave modport)
//   err        one-cycle pulse, request rejected
//   err_code   1 immediate out of range, 2 misaligned; held until next err
//   done       high after the req_last instruction has been written
//   full       high once 2**ADDR_W words have been written
//   word_count words written since start
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic                   done,
    output logic                   full,
    output logic [ADDR_W:0]        word_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] CLS_LOAD   = 3'd0;
    localparam logic [2:0] CLS_STORE  = 3'd1;
    localparam logic [2:0] CLS_R      = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_IALU   = 3'd4;
    localparam logic [2:0] CLS_JAL    = 3'd5;
    localparam logic [2:0] CLS_JALR   = 3'd6;
    localparam logic [2:0] CLS_AUIPC  = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RANGE    = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;

    // Capacity as a word_count value (2**ADDR_W).
    localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};

    // Signed inclusive range test used by every immediate check.
    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic                imem_we_r;
    logic [ADDR_W-1:0]   imem_addr_r;
    logic [31:0]         imem_wdata_r;
    logic                err_r;
    logic [1:0]          err_code_r;
    logic                done_r;
    logic                full_r;
    logic [ADDR_W:0]     word_count_r;
    logic                last_r;

    logic                req_ready_s;
    logic                accept_s;
    logic [31:0]         enc_word_s;
    logic [1:0]          enc_code_s;
    logic signed [31:0]  imm_s;
    logic [ADDR_W:0]     count_inc_s;

    assign imm_s       = $signed(bus.req_imm);
    assign req_ready_s = (state_r == ST_IDLE) && !full_r;
    // start blocks a same-cycle request from being taken.
    assign accept_s    = bus.req_valid && req_ready_s && !start;
    assign count_inc_s = word_count_r + (ADDR_W+1)'(1'b1);

    assign bus.req_ready  = req_ready_s;
    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = imem_wdata_r;
    assign err            = err_r;
    assign err_code       = err_code_r;
    assign done           = done_r;
    assign full           = full_r;
    assign word_count     = word_count_r;

    // Instruction encoder and immediate checker; range failure outranks misalignment.
    always_comb begin
        enc_word_s = 32'h0000_0000;
        enc_code_s = ERR_NONE;
        case (bus.req_class)
            CLS_LOAD: begin
                enc_word_s = {bus.req_imm[11:0], bus.req_rs1, bus.req_funct3,
                              bus.req_rd, OP_LOAD};
                if (!in_range(imm_s, -32'sd2048, 32'sd2047)) enc_code_s = ERR_RANGE;
                else                                         enc_code_s = ERR_NONE;
            end
            CLS_STORE: begin
                enc_word_s = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1,
                              bus.req_funct3, bus.req_imm[4:0], OP_STORE};
                if (!in_range(imm_s, -32'sd2048, 32'sd2047)) enc_code_s = ERR_RANGE;
                else                                         enc_code_s = ERR_NONE;
            end
            CLS_R: begin
                enc_word_s = {1'b0, bus.req_funct7b5, 5'b00000, bus.req_rs2,
                              bus.req_rs1, bus.req_funct3, bus.req_rd, OP_R};
            end
            CLS_BRANCH: begin
                enc_word_s = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2,
                              bus.req_rs1, bus.req_funct3, bus.req_imm[4:1],
                              bus.req_imm[11], OP_BRANCH};
                if (!in_range(imm_s, -32'sd4096, 32'sd4094)) enc_code_s = ERR_RANGE;
                else if (bus.req_imm[0])                     enc_code_s = ERR_MISALIGN;
                else                                         enc_code_s = ERR_NONE;
            end
            CLS_IALU: begin
                // funct3 001/101 are shifts: 5-bit shamt, bit 30 selects arithmetic.
                if ((bus.req_funct3 == 3'b001) || (bus.req_funct3 == 3'b101)) begin
                    enc_word_s = {1'b0, bus.req_funct7b5, 5'b00000, bus.req_imm[4:0],
                                  bus.req_rs1, bus.req_funct3, bus.req_rd, OP_IALU};
                    if (bus.req_imm[31:5] != 27'd0) enc_code_s = ERR_RANGE;
                    else                            enc_code_s = ERR_NONE;
                end else begin
                    enc_word_s = {bus.req_imm[11:0], bus.req_rs1, bus.req_funct3,
                                  bus.req_rd, OP_IALU};
                    if (!in_range(imm_s, -32'sd2048, 32'sd2047)) enc_code_s = ERR_RANGE;
                    else                                         enc_code_s = ERR_NONE;
                end
            end
            CLS_JAL: begin
                enc_word_s = {bus.req_imm[20], bus.req_imm[10:1], bus.req_imm[11],
                              bus.req_imm[19:12], bus.req_rd, OP_JAL};
                if (!in_range(imm_s, -32'sd1048576, 32'sd1048574)) enc_code_s = ERR_RANGE;
                else if (bus.req_imm[0])                           enc_code_s = ERR_MISALIGN;
                else                                               enc_code_s = ERR_NONE;
            end
            CLS_JALR: begin
                enc_word_s = {bus.req_imm[11:0], bus.req_rs1, 3'b000,
                              bus.req_rd, OP_JALR};
                if (!in_range(imm_s, -32'sd2048, 32'sd2047)) enc_code_s = ERR_RANGE;
                else                                         enc_code_s = ERR_NONE;
            end
            CLS_AUIPC: begin
                enc_word_s = {bus.req_imm[31:12], bus.req_rd, OP_AUIPC};
                if (bus.req_imm[11:0] != 12'h000) enc_code_s = ERR_MISALIGN;
                else                              enc_code_s = ERR_NONE;
            end
            default: begin
                enc_word_s = 32'h0000_0000;
                enc_code_s = ERR_NONE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // FSM next-state logic; start returns to IDLE from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (start) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (enc_code_s == ERR_NONE)) state_nxt_s = ST_WRITE;
                    else                                      state_nxt_s = ST_IDLE;
                end
                ST_WRITE: begin
                    if (last_r) state_nxt_s = ST_DONE;
                    else        state_nxt_s = ST_IDLE;
                end
                ST_DONE:  state_nxt_s = ST_DONE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Datapath: capture encoded word, write strobe, error report, address/count/status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'h0000_0000;
            err_r        <= 1'b0;
            err_code_r   <= ERR_NONE;
            done_r       <= 1'b0;
            full_r       <= 1'b0;
            word_count_r <= '0;
            last_r       <= 1'b0;
        end else if (start) begin
            // A write in flight still saw imem_we this cycle; its increment is dropped.
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            err_r        <= 1'b0;
            done_r       <= 1'b0;
            full_r       <= 1'b0;
            word_count_r <= '0;
        end else begin
            imem_we_r <= 1'b0;
            err_r     <= 1'b0;
            if (accept_s) begin
                if (enc_code_s != ERR_NONE) begin
                    err_r      <= 1'b1;
                    err_code_r <= enc_code_s;
                end else begin
                    imem_wdata_r <= enc_word_s;
                    imem_we_r    <= 1'b1;
                    last_r       <= bus.req_last;
                end
            end
            if (state_r == ST_WRITE) begin
                imem_addr_r  <= imem_addr_r + ADDR_W'(1'b1);
                word_count_r <= count_inc_s;
                if (count_inc_s == DEPTH_W) full_r <= 1'b1;
                if (last_r)                 done_r <= 1'b1;
            end
        end
    end

endmodule
